// File: rtl/ntt_pkg.sv
// Shared constants, mode encoding and FSM state type for the NTT stage scheduler.
package ntt_pkg;

    localparam int N          = 256;
    localparam int LOGN       = 8;
    localparam int ADDR_W     = LOGN;
    localparam int NUM_LAYERS = 7;
    localparam int TW_W       = 7;
    localparam int PAIRS      = N / 2;
    localparam int P_W        = LOGN - 1;

    typedef enum logic {
        MODE_NTT  = 1'b0,
        MODE_INTT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // log2 of the butterfly span: NTT halves the span each layer, INTT doubles it from 2.
    function automatic logic [2:0] len_log2(input mode_e m, input logic [2:0] lyr);
        return (m == MODE_NTT) ? 3'(LOGN - 1) - lyr : lyr + 3'd1;
    endfunction

endpackage

// File: rtl/ntt_stage_sched_if.sv
// Memory-side bus of the scheduler: read-pair issue with handshake, twiddle index and write-back.
interface ntt_stage_sched_if;
    import ntt_pkg::*;

    logic              rd_valid;
    logic              rd_ready;
    logic [LOGN-1:0]   rd_addr_a;
    logic [LOGN-1:0]   rd_addr_b;
    logic [TW_W-1:0]   tw_idx;
    logic              wr_en;
    logic [LOGN-1:0]   wr_addr_a;
    logic [LOGN-1:0]   wr_addr_b;

    modport master (
        output rd_valid, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b,
        output rd_ready
    );

endinterface

// File: rtl/ntt_addr_delay.sv
// Fixed-depth shift register that replays accepted read addresses as write-backs
// after the butterfly latency.
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int DEPTH = 6
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LOGN-1:0]   in_addr_a,
    input  logic [LOGN-1:0]   in_addr_b,
    output logic              out_valid,
    output logic [LOGN-1:0]   out_addr_a,
    output logic [LOGN-1:0]   out_addr_b
);

    logic [DEPTH-1:0] vld_sr;
    logic [LOGN-1:0]  a_sr [DEPTH];
    logic [LOGN-1:0]  b_sr [DEPTH];

    // Shift every cycle; reset flushes in-flight entries so nothing is written back.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= in_valid;
            a_sr[0]   <= in_addr_a;
            b_sr[0]   <= in_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                a_sr[i]   <= a_sr[i-1];
                b_sr[i]   <= b_sr[i-1];
            end
        end
    end

    assign out_valid  = vld_sr[DEPTH-1];
    assign out_addr_a = a_sr[DEPTH-1];
    assign out_addr_b = b_sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sched.sv
// Layer sequencer for a 256-point NTT/INTT: issues one butterfly pair per accepted cycle,
// replays the addresses as write-backs BF_LAT cycles later and drains between layers.
module ntt_stage_sched
    import ntt_pkg::*;
#(
    parameter int BF_LAT = 6
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_in,
    ntt_stage_sched_if.master  bus,
    output logic [2:0]         layer,
    output logic               busy,
    output logic               layer_done,
    output logic               done
);

    localparam int               CNT_W      = $clog2(BF_LAT + 1);
    localparam logic [P_W-1:0]   LAST_P     = P_W'(PAIRS - 1);
    localparam logic [2:0]       LAST_LAYER = 3'(NUM_LAYERS - 1);

    state_e              state, state_d;
    logic [P_W-1:0]      p, p_d;
    logic [2:0]          layer_d;
    mode_e               mode_q, mode_d;
    logic [CNT_W-1:0]    cnt, cnt_d;

    logic                issue;
    logic                accept;
    logic [2:0]          lg;
    logic [ADDR_W-1:0]   len;
    logic [ADDR_W-1:0]   grp;
    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic [TW_W-1:0]     g_base;
    logic [TW_W-1:0]     tw_full;
    logic [ADDR_W-1:0]   rd_a;
    logic [ADDR_W-1:0]   rd_b;
    logic                wr_en_w;
    logic [ADDR_W-1:0]   wr_a_w;
    logic [ADDR_W-1:0]   wr_b_w;

    assign issue  = (state == ST_ISSUE);
    assign accept = issue & bus.rd_ready;

    // Control registers: FSM state, pair counter, layer, latched mode and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            p      <= '0;
            layer  <= '0;
            mode_q <= MODE_NTT;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            p      <= p_d;
            layer  <= layer_d;
            mode_q <= mode_d;
            cnt    <= cnt_d;
        end
    end

    // Next-state and status: pairs advance only on accept, drain waits out the butterfly latency.
    always_comb begin
        state_d    = state;
        p_d        = p;
        layer_d    = layer;
        mode_d     = mode_q;
        cnt_d      = cnt;
        busy       = 1'b0;
        layer_done = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    state_d = ST_ISSUE;
                    p_d     = '0;
                    layer_d = '0;
                    mode_d  = mode_e'(mode_in);
                end
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (accept) begin
                    if (p == LAST_P) begin
                        state_d = ST_DRAIN;
                        p_d     = '0;
                        cnt_d   = CNT_W'(BF_LAT);
                    end else begin
                        p_d = p + P_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    layer_done = 1'b1;
                    if (layer == LAST_LAYER) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        layer_d = layer + 3'd1;
                        p_d     = '0;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Butterfly address and twiddle index from the registered pair counter and layer.
    always_comb begin
        lg      = len_log2(mode_q, layer);
        len     = ADDR_W'(1) << lg;
        grp     = ADDR_W'(p) >> lg;
        off     = ADDR_W'(p) & (len - ADDR_W'(1));
        addr_a  = (grp << ({1'b0, lg} + 4'd1)) | off;
        addr_b  = addr_a + len;
        g_base  = TW_W'(1) << (3'(LOGN - 1) - lg);
        tw_full = (mode_q == MODE_NTT) ? g_base + TW_W'(grp)
                                       : (g_base << 1) - TW_W'(1) - TW_W'(grp);
    end

    assign rd_a          = issue ? addr_a : '0;
    assign rd_b          = issue ? addr_b : '0;
    assign bus.rd_valid  = issue;
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_idx    = issue ? tw_full : '0;

    ntt_addr_delay #(
        .DEPTH (BF_LAT)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept),
        .in_addr_a  (rd_a),
        .in_addr_b  (rd_b),
        .out_valid  (wr_en_w),
        .out_addr_a (wr_a_w),
        .out_addr_b (wr_b_w)
    );

    assign bus.wr_en     = wr_en_w;
    assign bus.wr_addr_a = wr_a_w;
    assign bus.wr_addr_b = wr_b_w;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched: full NTT/INTT runs, stalls, ignored starts,
// restart from DONE, mid-run reset and a BF_LAT=1 build running alongside.
module tb_ntt_stage_sched;
    import ntt_pkg::*;

    localparam int BF_LAT  = 6;
    localparam int BF_LAT2 = 1;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode_in;
    logic [2:0] layer, layer2;
    logic       busy, busy2;
    logic       layer_done, layer_done2;
    logic       done, done2;

    ntt_stage_sched_if bus();
    ntt_stage_sched_if bus2();

    assign bus2.rd_ready = 1'b1;

    ntt_stage_sched #(.BF_LAT(BF_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_in    (mode_in),
        .bus        (bus),
        .layer      (layer),
        .busy       (busy),
        .layer_done (layer_done),
        .done       (done)
    );

    ntt_stage_sched #(.BF_LAT(BF_LAT2)) dut_lat1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_in    (mode_in),
        .bus        (bus2),
        .layer      (layer2),
        .busy       (busy2),
        .layer_done (layer_done2),
        .done       (done2)
    );

    typedef struct {
        int a;
        int b;
        int tw;
        int lyr;
        int cyc;
    } acc_t;

    acc_t acc_log[$];
    acc_t pend[$];
    acc_t exp_q[$];
    acc_t acc2_log[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ld2_cnt = 0;
    int   idle2_cnt = 0;
    logic stall_prev = 1'b0;
    logic ld_prev = 1'b0;
    int   prev_a, prev_b, prev_tw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pair order written as the textbook nested loops with a running twiddle index.
    task automatic build_model(input logic m);
        acc_t e;
        int   k;
        int   len;
        exp_q.delete();
        k = m ? 127 : 1;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            len = m ? (2 << l) : (128 >> l);
            for (int s = 0; s < N; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    e.a = j; e.b = j + len; e.tw = k; e.lyr = l; e.cyc = 0;
                    exp_q.push_back(e);
                end
                k = m ? k - 1 : k + 1;
            end
        end
    endtask

    // Negedge monitor: write-back latency/order, stall hold, layer_done alignment, layer ordering.
    task automatic monitor_loop();
        acc_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend.delete();
                stall_prev = 1'b0;
                ld_prev    = 1'b0;
            end else begin
                if (bus2.rd_valid) begin
                    e.a = int'(bus2.rd_addr_a); e.b = int'(bus2.rd_addr_b);
                    e.tw = int'(bus2.tw_idx); e.lyr = int'(layer2); e.cyc = cyc;
                    acc2_log.push_back(e);
                end
                if (layer_done2) ld2_cnt++;
                if (busy2 && !bus2.rd_valid) idle2_cnt++;

                if (bus.wr_en) begin
                    checks++;
                    if (pend.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL wr_orphan: wr_en=1 at cycle %0d, required 0 (no outstanding read)", cyc);
                    end else begin
                        e = pend.pop_front();
                        if (cyc - e.cyc !== BF_LAT || int'(bus.wr_addr_a) !== e.a || int'(bus.wr_addr_b) !== e.b) begin
                            errors++;
                            $display("[TB] FAIL wr_replay: got lat=%0d a=%0d b=%0d, required lat=%0d a=%0d b=%0d",
                                     cyc - e.cyc, bus.wr_addr_a, bus.wr_addr_b, BF_LAT, e.a, e.b);
                        end
                    end
                end
                if (layer_done) begin
                    checks++;
                    if (bus.wr_en !== 1'b1 || pend.size() != 0) begin
                        errors++;
                        $display("[TB] FAIL layer_done_align: got wr_en=%0b outstanding=%0d, required wr_en=1 outstanding=0",
                                 bus.wr_en, pend.size());
                    end
                end
                if (stall_prev) begin
                    checks++;
                    if (bus.rd_valid !== 1'b1 || int'(bus.rd_addr_a) !== prev_a ||
                        int'(bus.rd_addr_b) !== prev_b || int'(bus.tw_idx) !== prev_tw) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got v=%0b a=%0d b=%0d tw=%0d, required v=1 a=%0d b=%0d tw=%0d",
                                 bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, prev_a, prev_b, prev_tw);
                    end
                end
                if (ld_prev && !done) begin
                    checks++;
                    if (bus.rd_valid !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL next_layer_issue: got rd_valid=%0b, required 1", bus.rd_valid);
                    end
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    checks++;
                    if (pend.size() > 0 && pend[0].lyr != int'(layer)) begin
                        errors++;
                        $display("[TB] FAIL raw_order: got read of layer %0d with layer %0d writes outstanding, required none",
                                 layer, pend[0].lyr);
                    end
                    e.a = int'(bus.rd_addr_a); e.b = int'(bus.rd_addr_b);
                    e.tw = int'(bus.tw_idx); e.lyr = int'(layer); e.cyc = cyc;
                    pend.push_back(e);
                    acc_log.push_back(e);
                end
                stall_prev = bus.rd_valid && !bus.rd_ready;
                prev_a     = int'(bus.rd_addr_a);
                prev_b     = int'(bus.rd_addr_b);
                prev_tw    = int'(bus.tw_idx);
                ld_prev    = layer_done;
            end
        end
    endtask

    // One whole transform: pulse start, drive rd_ready, optionally poke start/mode while busy.
    task automatic run_transform(input logic m, input bit rnd, input bit poke,
                                 output int cycles, output int pulses);
        acc_log.delete();
        mode_in      = m;
        start        = 1'b1;
        bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cycles       = 0;
        pulses       = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            start = 1'b0;
            if (layer_done) pulses++;
            if (poke && busy && (cycles % 250 == 20)) begin
                start   = 1'b1;
                mode_in = ~mode_in;
            end
            bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end while (!done && cycles < 6000);
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_timeout: got done=%0b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode_in = 1'b0; bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %0b, required 0", bus.rd_valid); end
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0b, required 0", bus.wr_en); end
        checks++;
        if (bus.rd_addr_a !== 8'd0 || bus.rd_addr_b !== 8'd0 || bus.tw_idx !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_rd_bus: got a=%0d b=%0d tw=%0d, required 0 0 0", bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx);
        end
        checks++;
        if (layer !== 3'd0 || busy !== 1'b0 || layer_done !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got layer=%0d busy=%0b ld=%0b done=%0b, required 0 0 0 0",
                     layer, busy, layer_done, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_ntt_full();
        int c, pl;
        run_transform(1'b0, 1'b0, 1'b0, c, pl);
        checks++;
        if (c !== 7 * (128 + BF_LAT) + 1) begin errors++; $display("[TB] FAIL ntt_cycles: got %0d, required %0d", c, 7 * (128 + BF_LAT) + 1); end
        checks++;
        if (pl !== 7) begin errors++; $display("[TB] FAIL ntt_layer_done_count: got %0d, required 7", pl); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ntt_busy_in_done: got %0b, required 0", busy); end
        build_model(1'b0);
        checks++;
        if (acc_log.size() != 896) begin errors++; $display("[TB] FAIL ntt_accepts: got %0d, required 896", acc_log.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i].a !== exp_q[i].a || acc_log[i].b !== exp_q[i].b ||
                acc_log[i].tw !== exp_q[i].tw || acc_log[i].lyr !== exp_q[i].lyr) begin
                errors++;
                $display("[TB] FAIL ntt_pair[%0d]: got (%0d,%0d) tw%0d L%0d, required (%0d,%0d) tw%0d L%0d", i,
                         acc_log[i].a, acc_log[i].b, acc_log[i].tw, acc_log[i].lyr,
                         exp_q[i].a, exp_q[i].b, exp_q[i].tw, exp_q[i].lyr);
            end
        end
        if (acc_log.size() == 896) begin
            checks++;
            if (acc_log[0].a !== 0 || acc_log[0].b !== 128 || acc_log[0].tw !== 1) begin
                errors++; $display("[TB] FAIL ntt_l0_first: got (%0d,%0d) tw%0d, required (0,128) tw1", acc_log[0].a, acc_log[0].b, acc_log[0].tw);
            end
            checks++;
            if (acc_log[127].a !== 127 || acc_log[127].b !== 255 || acc_log[127].tw !== 1) begin
                errors++; $display("[TB] FAIL ntt_l0_last: got (%0d,%0d) tw%0d, required (127,255) tw1", acc_log[127].a, acc_log[127].b, acc_log[127].tw);
            end
            checks++;
            if (acc_log[128].a !== 0 || acc_log[128].b !== 64 || acc_log[128].tw !== 2) begin
                errors++; $display("[TB] FAIL ntt_l1_first: got (%0d,%0d) tw%0d, required (0,64) tw2", acc_log[128].a, acc_log[128].b, acc_log[128].tw);
            end
            checks++;
            if (acc_log[192].a !== 128 || acc_log[192].b !== 192 || acc_log[192].tw !== 3) begin
                errors++; $display("[TB] FAIL ntt_l1_p64: got (%0d,%0d) tw%0d, required (128,192) tw3", acc_log[192].a, acc_log[192].b, acc_log[192].tw);
            end
            checks++;
            if (acc_log[768].a !== 0 || acc_log[768].b !== 2 || acc_log[768].tw !== 64) begin
                errors++; $display("[TB] FAIL ntt_l6_first: got (%0d,%0d) tw%0d, required (0,2) tw64", acc_log[768].a, acc_log[768].b, acc_log[768].tw);
            end
            checks++;
            if (acc_log[895].a !== 253 || acc_log[895].b !== 255 || acc_log[895].tw !== 127) begin
                errors++; $display("[TB] FAIL ntt_l6_last: got (%0d,%0d) tw%0d, required (253,255) tw127", acc_log[895].a, acc_log[895].b, acc_log[895].tw);
            end
        end
    endtask

    task automatic test_intt_full();
        int c, pl;
        run_transform(1'b1, 1'b0, 1'b0, c, pl);
        checks++;
        if (c !== 7 * (128 + BF_LAT) + 1) begin errors++; $display("[TB] FAIL intt_cycles: got %0d, required %0d", c, 7 * (128 + BF_LAT) + 1); end
        checks++;
        if (pl !== 7) begin errors++; $display("[TB] FAIL intt_layer_done_count: got %0d, required 7", pl); end
        build_model(1'b1);
        checks++;
        if (acc_log.size() != 896) begin errors++; $display("[TB] FAIL intt_accepts: got %0d, required 896", acc_log.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i].a !== exp_q[i].a || acc_log[i].b !== exp_q[i].b ||
                acc_log[i].tw !== exp_q[i].tw || acc_log[i].lyr !== exp_q[i].lyr) begin
                errors++;
                $display("[TB] FAIL intt_pair[%0d]: got (%0d,%0d) tw%0d L%0d, required (%0d,%0d) tw%0d L%0d", i,
                         acc_log[i].a, acc_log[i].b, acc_log[i].tw, acc_log[i].lyr,
                         exp_q[i].a, exp_q[i].b, exp_q[i].tw, exp_q[i].lyr);
            end
        end
        if (acc_log.size() == 896) begin
            checks++;
            if (acc_log[0].a !== 0 || acc_log[0].b !== 2 || acc_log[0].tw !== 127) begin
                errors++; $display("[TB] FAIL intt_l0_first: got (%0d,%0d) tw%0d, required (0,2) tw127", acc_log[0].a, acc_log[0].b, acc_log[0].tw);
            end
            checks++;
            if (acc_log[2].a !== 4 || acc_log[2].b !== 6 || acc_log[2].tw !== 126) begin
                errors++; $display("[TB] FAIL intt_l0_grp1: got (%0d,%0d) tw%0d, required (4,6) tw126", acc_log[2].a, acc_log[2].b, acc_log[2].tw);
            end
            checks++;
            if (acc_log[768].a !== 0 || acc_log[768].b !== 128 || acc_log[768].tw !== 1) begin
                errors++; $display("[TB] FAIL intt_l6_first: got (%0d,%0d) tw%0d, required (0,128) tw1", acc_log[768].a, acc_log[768].b, acc_log[768].tw);
            end
        end
    endtask

    task automatic test_random_ready();
        int c, pl;
        run_transform(1'b0, 1'b1, 1'b0, c, pl);
        checks++;
        if (pl !== 7) begin errors++; $display("[TB] FAIL rnd_layer_done_count: got %0d, required 7", pl); end
        build_model(1'b0);
        checks++;
        if (acc_log.size() != 896) begin errors++; $display("[TB] FAIL rnd_accepts: got %0d, required 896", acc_log.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i].a !== exp_q[i].a || acc_log[i].b !== exp_q[i].b || acc_log[i].tw !== exp_q[i].tw) begin
                errors++;
                $display("[TB] FAIL rnd_pair[%0d]: got (%0d,%0d) tw%0d, required (%0d,%0d) tw%0d", i,
                         acc_log[i].a, acc_log[i].b, acc_log[i].tw, exp_q[i].a, exp_q[i].b, exp_q[i].tw);
            end
        end
    endtask

    task automatic test_start_ignored();
        int c, pl;
        run_transform(1'b1, 1'b0, 1'b1, c, pl);
        checks++;
        if (c !== 7 * (128 + BF_LAT) + 1) begin errors++; $display("[TB] FAIL poke_cycles: got %0d, required %0d", c, 7 * (128 + BF_LAT) + 1); end
        build_model(1'b1);
        checks++;
        if (acc_log.size() != 896) begin errors++; $display("[TB] FAIL poke_accepts: got %0d, required 896", acc_log.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i].a !== exp_q[i].a || acc_log[i].b !== exp_q[i].b || acc_log[i].tw !== exp_q[i].tw) begin
                errors++;
                $display("[TB] FAIL poke_pair[%0d]: got (%0d,%0d) tw%0d, required (%0d,%0d) tw%0d", i,
                         acc_log[i].a, acc_log[i].b, acc_log[i].tw, exp_q[i].a, exp_q[i].b, exp_q[i].tw);
            end
        end
    endtask

    task automatic test_restart_from_done();
        int n;
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL restart_pre_done: got %0b, required 1", done); end
        mode_in = 1'b0; bus.rd_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || layer !== 3'd0 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_state: got done=%0b layer=%0d rd_valid=%0b, required 0 0 1", done, layer, bus.rd_valid);
        end
        checks++;
        if (bus.rd_addr_a !== 8'd0 || bus.rd_addr_b !== 8'd128 || bus.tw_idx !== 7'd1) begin
            errors++;
            $display("[TB] FAIL restart_first_pair: got (%0d,%0d) tw%0d, required (0,128) tw1", bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx);
        end
        n = 1;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 7 * (128 + BF_LAT) + 1) begin errors++; $display("[TB] FAIL restart_cycles: got %0d, required %0d", n, 7 * (128 + BF_LAT) + 1); end
    endtask

    task automatic test_mid_reset();
        int  n, k, c, pl;
        logic wr_seen;
        mode_in = 1'b0; bus.rd_ready = 1'b1; start = 1'b1;
        n = 0; k = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (layer == 3'd3 && bus.rd_valid) k++;
        end while (k < 50 && n < 2000);
        checks++;
        if (k !== 50) begin errors++; $display("[TB] FAIL midrst_reach: got %0d layer-3 cycles, required 50", k); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0 || layer !== 3'd0 ||
            done !== 1'b0 || layer_done !== 1'b0 || bus.rd_addr_a !== 8'd0 || bus.rd_addr_b !== 8'd0 || bus.tw_idx !== 7'd0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got v=%0b wr=%0b busy=%0b layer=%0d done=%0b ld=%0b a=%0d b=%0d tw=%0d, required all 0",
                     bus.rd_valid, bus.wr_en, busy, layer, done, layer_done, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx);
        end
        rst = 1'b0;
        wr_seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.wr_en || busy) wr_seen = 1'b1;
        end
        checks++;
        if (wr_seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet: got wr_en/busy activity=%0b, required 0", wr_seen); end
        run_transform(1'b0, 1'b0, 1'b0, c, pl);
        checks++;
        if (c !== 7 * (128 + BF_LAT) + 1 || pl !== 7 || acc_log.size() != 896) begin
            errors++;
            $display("[TB] FAIL midrst_rerun: got cycles=%0d pulses=%0d accepts=%0d, required %0d 7 896",
                     c, pl, acc_log.size(), 7 * (128 + BF_LAT) + 1);
        end
    endtask

    task automatic test_bf_lat1();
        int n;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        acc2_log.delete(); ld2_cnt = 0; idle2_cnt = 0;
        mode_in = 1'b0; bus.rd_ready = 1'b1; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (!done2 && n < 3000);
        checks++;
        if (n !== 7 * (128 + BF_LAT2) + 1) begin errors++; $display("[TB] FAIL lat1_cycles: got %0d, required %0d", n, 7 * (128 + BF_LAT2) + 1); end
        checks++;
        if (ld2_cnt !== 7) begin errors++; $display("[TB] FAIL lat1_layer_done_count: got %0d, required 7", ld2_cnt); end
        checks++;
        if (idle2_cnt !== 7) begin errors++; $display("[TB] FAIL lat1_gap_cycles: got %0d, required 7", idle2_cnt); end
        build_model(1'b0);
        checks++;
        if (acc2_log.size() != 896) begin errors++; $display("[TB] FAIL lat1_accepts: got %0d, required 896", acc2_log.size()); end
        for (int i = 0; i < exp_q.size() && i < acc2_log.size(); i++) begin
            checks++;
            if (acc2_log[i].a !== exp_q[i].a || acc2_log[i].b !== exp_q[i].b || acc2_log[i].tw !== exp_q[i].tw) begin
                errors++;
                $display("[TB] FAIL lat1_pair[%0d]: got (%0d,%0d) tw%0d, required (%0d,%0d) tw%0d", i,
                         acc2_log[i].a, acc2_log[i].b, acc2_log[i].tw, exp_q[i].a, exp_q[i].b, exp_q[i].tw);
            end
        end
    endtask

    // Test sequence with the monitor running alongside.
    initial begin
        rst = 1'b1; start = 1'b0; mode_in = 1'b0; bus.rd_ready = 1'b0;
        fork
            monitor_loop();
        join_none
        $display("[TB] reset");
        test_reset();
        $display("[TB] NTT full run");
        test_ntt_full();
        $display("[TB] INTT full run");
        test_intt_full();
        $display("[TB] random rd_ready");
        test_random_ready();
        $display("[TB] start/mode poked while busy");
        test_start_ignored();
        $display("[TB] restart from DONE");
        test_restart_from_done();
        $display("[TB] reset mid-run");
        test_mid_reset();
        $display("[TB] BF_LAT=1 build");
        test_bf_lat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
